d_flip_flop: RTL and testbench
==============================

Name: d_flip_flop

Overview:
- Clocked D-type storage element with synchronous clear, synchronous set, load enable and complementary output.
- Parameterised width. WIDTH=1 is the single-bit cell that register blocks instantiate once per bit, e.g. three instances form a 3-bit state register.
- Leaf cell: no submodules, no combinational path from D to Q.

Parameters:
- WIDTH, 1, number of stored bits.
- RESET_VAL, 0 (WIDTH bits), value loaded into Q by Clr.
- SET_VAL, all ones (WIDTH bits), value loaded into Q by Set.

Ports:
- Clk  input  1  clock; all state changes on the rising edge only.
- Clr  input  1  synchronous, active-high clear. "Clr" is the active-high counterpart of the codebase's ClrN naming.
- D  input  WIDTH  data to capture.
- En  input  1  load enable, active-high. Tie to 1 for plain D-FF use.
- Set  input  1  synchronous, active-high preset.
- Q  output  WIDTH  stored value.
- QN  output  WIDTH  bitwise complement of Q, always ~Q.

Behaviour:
- Interface: one clock (Clk); reset (Clr) is synchronous and active-high.
- Q updates only on a rising edge of Clk. Between edges, Q holds regardless of D, En, Set or Clr activity.
- Priority at each rising edge:
  1. Clr=1: Q <= RESET_VAL.
  2. Else Set=1: Q <= SET_VAL.
  3. Else En=1: Q <= D.
  4. Else: Q holds.
- Latency: D sampled at edge n is visible on Q immediately after edge n, a 1-cycle register delay. D changes after the edge do not affect Q until the next edge.
- Clr and Set together: Clr wins.
- Clr held across many edges: Q stays RESET_VAL and D is ignored.
- First edge after Clr deasserts: normal load per Set/En.
- Asserting or deasserting Clr mid-cycle has no effect until the next rising edge. There is no asynchronous path.
- Power-up: Q is undefined until the first edge with Clr=1. Simulation may show X. The bench must apply Clr before checking.
- QN is purely combinational from Q: QN = ~Q at all times, including after reset (QN = ~RESET_VAL).
- Width rules: D, Q, QN are exactly WIDTH bits with no truncation or extension inside the cell. Parents drive exactly WIDTH bits.
- Falling edges of Clk have no effect.

Optional Feature:
- Macro: DFF_CHG_EN.
- Defined: adds output Chg (WIDTH bits).
  - Registered: Chg <= (next Q) ^ Q at every rising edge, so Chg flags the bits that changed at the most recent edge.
  - Chg is 0 during and after a clearing edge when Q was already RESET_VAL. Chg is cleared to 0 while Clr=1 on the edge.
  - Chg = 0 after any holding edge.
- Not defined: the Chg port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset: WIDTH=3, Clr=1, D cycles 0..7 over 8 edges, En=1 -> Q=000 and QN=111 after every edge.
- Load: Clr=0, En=1, D=0..7 on successive edges -> after each edge Q equals that edge's D (e.g. D=5 -> Q=101, QN=010). Q is unchanged between edges.
- Hold: Q=110, En=0, D=001 for 3 edges -> Q stays 110.
- Priority: Clr=1, Set=1, D=101 -> Q=RESET_VAL (000). Then Clr=0, Set=1 -> Q=111. Then Set=0, En=1, D=010 -> Q=010.
- Edge/sync: Q=011, toggle Clr high then low between rising edges, and toggle D, without a rising edge -> Q stays 011. Falling edge with Clr=1 -> no change.
- Optional (DFF_CHG_EN): Q=000, load D=101 -> Chg=101. Next edge loads D=101 -> Chg=000. Clr edge -> Chg=000.

Source files
------------

// File: rtl/d_flip_flop.sv
// -----------------------------------------------------------------------------
// d_flip_flop
//
// Purpose:
//   Clocked D-type storage cell with synchronous clear, synchronous set,
//   load enable and a complementary output. The width is a parameter.
//   WIDTH=1 is the single-bit cell that register blocks instantiate once per
//   bit. This is a leaf cell: it has no submodules and no combinational path
//   from D to Q.
//
// Parameters:
//   WIDTH     - number of stored bits
//   RESET_VAL - value loaded into Q by Clr (default all zeros)
//   SET_VAL   - value loaded into Q by Set (default all ones)
//
// Ports:
//   Clk  in   1      clock; all state changes happen on the rising edge
//   Clr  in   1      synchronous active-high clear (highest priority)
//   D    in   WIDTH  data to capture
//   En   in   1      active-high load enable
//   Set  in   1      synchronous active-high preset (below Clr)
//   Q    out  WIDTH  stored value
//   QN   out  WIDTH  bitwise complement of Q
//   Chg  out  WIDTH  (only when DFF_CHG_EN is defined) registered mask of the
//                    bits of Q that changed at the most recent rising edge
//
// Optional feature macro: DFF_CHG_EN
// -----------------------------------------------------------------------------
module d_flip_flop #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] D,
  input  logic             En,
  input  logic             Set,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN
`ifdef DFF_CHG_EN
  ,
  output logic [WIDTH-1:0] Chg
`endif
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state selection: Clr beats Set, Set beats En, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (Clr) begin
      q_d = RESET_VAL;
    end else if (Set) begin
      q_d = SET_VAL;
    end else if (En) begin
      q_d = D;
    end
  end

  always_ff @(posedge Clk) begin
    q_q <= q_d;
  end

  assign Q = q_q;

  // QN is derived from the stored value only, so it tracks Q at all times
  // and never sees D directly.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_qn
      assign QN[gi] = ~q_q[gi];
    end
  endgenerate

`ifdef DFF_CHG_EN
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] chg_d;

  // A clearing edge always reports no change, even if Q moves to RESET_VAL;
  // this keeps the mask well defined while Q is still unknown at power-up.
  always_comb begin
    chg_d = '0;
    if (!Clr) begin
      chg_d = q_d ^ q_q;
    end
  end

  always_ff @(posedge Clk) begin
    chg_q <= chg_d;
  end

  assign Chg = chg_q;
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// -----------------------------------------------------------------------------
// tb_d_flip_flop
//
// Self-checking bench for d_flip_flop at WIDTH=3. Each stimulus step drives
// inputs on the falling edge, pushes the expected post-edge result into a
// scoreboard queue, and pops/compares it just after the next rising edge.
// Q is also checked mid-cycle to confirm it does not follow the inputs.
// Build with +define+DFF_CHG_EN to also check the Chg output.
// -----------------------------------------------------------------------------
module tb_d_flip_flop;

  localparam int         W  = 3;
  localparam logic [2:0] RV = 3'b000;
  localparam logic [2:0] SV = 3'b111;

  logic         Clk;
  logic         Clr;
  logic [W-1:0] D;
  logic         En;
  logic         Set;
  logic [W-1:0] Q;
  logic [W-1:0] QN;
`ifdef DFF_CHG_EN
  logic [W-1:0] Chg;
`endif

  d_flip_flop #(
    .WIDTH    (W),
    .RESET_VAL(RV),
    .SET_VAL  (SV)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .D  (D),
    .En (En),
    .Set(Set),
    .Q  (Q),
    .QN (QN)
`ifdef DFF_CHG_EN
    ,
    .Chg(Chg)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] q;
    logic [2:0] chg;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] model_q;
  bit         model_valid = 0;

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%b exp=%b ok", tag, obs, exp);
    end else begin
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Pop one scoreboard entry and compare it against the DUT outputs.
  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", Q, 3'bxxx);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, "_q"}, Q, e.q);
    check_eq({e.tag, "_qn"}, QN, ~e.q);
`ifdef DFF_CHG_EN
    check_eq({e.tag, "_chg"}, Chg, e.chg);
`endif
  endtask

  // Push an expected result derived from the behavioural rules.
  task automatic push_expect(input logic clr, input logic set, input logic en,
                             input logic [2:0] d, input string tag);
    exp_t       e;
    logic [2:0] nq;
    if (clr)      nq = RV;
    else if (set) nq = SV;
    else if (en)  nq = d;
    else          nq = model_q;
    e.q   = nq;
    e.chg = clr ? 3'b000 : (nq ^ model_q);
    e.tag = tag;
    sb.push_back(e);
    model_q     = nq;
    model_valid = 1;
  endtask

  // One clocked transaction: drive on the falling edge, check after the rise.
  task automatic step(input logic clr, input logic set, input logic en,
                      input logic [2:0] d, input string tag);
    logic [2:0] prev_q;
    @(negedge Clk);
    Clr = clr;
    Set = set;
    En  = en;
    D   = d;
    prev_q = model_q;
    push_expect(clr, set, en, d, tag);
    #1;
    if (model_valid && !$isunknown(prev_q)) check_eq({tag, "_mid"}, Q, prev_q);
    @(posedge Clk);
    #1;
    compare_pop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] r;
    Clr = 1'b1;
    Set = 1'b0;
    En  = 1'b1;
    D   = 3'b000;
    model_q = 3'bxxx;

    // Clr held across 8 edges while D walks 0..7: Q must stay RESET_VAL.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 3'(i), $sformatf("rst%0d", i));

    // Plain loads.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 3'(i), $sformatf("load%0d", i));

    // Hold with En=0 while D differs.
    step(1'b0, 1'b0, 1'b1, 3'b110, "hold_ld");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 3'b001, $sformatf("hold%0d", i));

    // Priority: Clr over Set, Set over En, then a normal load.
    step(1'b1, 1'b1, 1'b1, 3'b101, "pri_clr");
    step(1'b0, 1'b1, 1'b1, 3'b101, "pri_set");
    step(1'b0, 1'b0, 1'b1, 3'b010, "pri_load");

    // Mid-cycle Clr/D activity and a falling edge with Clr=1 have no effect.
    step(1'b0, 1'b0, 1'b1, 3'b011, "sync_ld");
    #1;
    Clr = 1'b1;
    D   = 3'b100;
    #1;
    check_eq("sync_clr_mid", Q, 3'b011);
    @(negedge Clk);
    #1;
    check_eq("sync_fall", Q, 3'b011);
    Clr = 1'b0;
    En  = 1'b0;
    D   = 3'b000;
    push_expect(1'b0, 1'b0, 1'b0, 3'b000, "sync_hold");
    @(posedge Clk);
    #1;
    compare_pop();

    // Change-mask sequence (Q is checked in every build).
    step(1'b1, 1'b0, 1'b1, 3'b000, "chg_clr0");
    step(1'b0, 1'b0, 1'b1, 3'b101, "chg_ld5");
    step(1'b0, 1'b0, 1'b1, 3'b101, "chg_same");
    step(1'b1, 1'b0, 1'b1, 3'b010, "chg_clr1");

    // Short random mix.
    for (int i = 0; i < 16; i++) begin
      r = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), r, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
